// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared definitions for the SIMD pipeline control logic:
//   - FWD_RF / FWD_WB / FWD_MEM : encodings of the execute-stage operand mux3 select
//   - mc_state_t                : multi-cycle sequencer states
//   - e_tag_t / mw_tag_t        : shadow register tags kept for E and for M/W
//   - fwd_select()              : forwarding decision for one execute-stage operand
// Register addresses are held zero-extended to TAG_AW bits inside the tags, so any
// register address width up to TAG_AW can share these types.
package pipeline_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int TAG_AW   = 8;
  localparam int MC_CNT_W = 4;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_t;

  typedef struct packed {
    logic [TAG_AW-1:0] ra1;
    logic [TAG_AW-1:0] ra2;
    logic [TAG_AW-1:0] wa;
    logic              rw;
    logic              m2r;
  } e_tag_t;

  typedef struct packed {
    logic [TAG_AW-1:0] wa;
    logic              rw;
  } mw_tag_t;

  // M is younger than W, so its value is the most recent one and wins.
  // Register 0 is an ordinary register here and is forwarded like any other.
  function automatic logic [1:0] fwd_select(input logic [TAG_AW-1:0] ra,
                                            input mw_tag_t           m_tag,
                                            input mw_tag_t           w_tag);
    if (m_tag.rw && (m_tag.wa == ra)) begin
      return FWD_MEM;
    end else if (w_tag.rw && (w_tag.wa == ra)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/mc_sequencer.sv
// mc_sequencer
// Holds a multi-cycle vector op in the execute stage for MC_CYCLES cycles in total.
// Ports:
//   clk     in  : rising-edge clock
//   reset   in  : synchronous, active-high
//   mc_e    in  : the instruction currently in E is a multi-cycle op
//   stall_e out : hold the execute pipeline register this cycle
// The op's first cycle in E is seen while still MC_IDLE; stall_e is raised right away
// so the op cannot slip out of E on that first edge. The counter then counts the
// remaining cycles down; in the cycle it reads 1 the op finishes, stall_e drops so
// E can advance, and the FSM is back in MC_IDLE the cycle after. A following
// multi-cycle op therefore starts stalling in the very cycle it reaches E.
module mc_sequencer
  import pipeline_pkg::*;
#(
  parameter int MC_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic mc_e,
  output logic stall_e
);

  localparam logic [MC_CNT_W-1:0] CNT_LOAD = MC_CNT_W'(MC_CYCLES - 1);

  mc_state_t           state_q, state_d;
  logic [MC_CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MC_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    stall_e = 1'b0;
    case (state_q)
      MC_IDLE: begin
        if (mc_e) begin
          stall_e = 1'b1;
          state_d = MC_BUSY;
          count_d = CNT_LOAD;
        end
      end
      MC_BUSY: begin
        // Count 1 is the op's final cycle in E: release E and return to idle.
        if (count_q > MC_CNT_W'(1)) begin
          stall_e = 1'b1;
          count_d = count_q - MC_CNT_W'(1);
        end else begin
          state_d = MC_IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = MC_IDLE;
        count_d = '0;
      end
    endcase
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit
// Pipeline control stage: drives the execute-stage operand mux3 selects and the
// fetch/decode/execute stall and flush lines. It shadows the register tags of the
// instructions in E, M and W itself, so it needs only the decode-stage fields.
// Ports:
//   clk, reset                 : rising-edge clock, synchronous active-high reset
//   ra1_d, ra2_d, wa_d         : decode-stage source / destination register addresses
//   reg_write_d, mem_to_reg_d  : decode instruction writes the register file / is a load
//   multicycle_d               : decode instruction is a multi-cycle vector op
//   branch_taken_e             : branch in E resolved taken
//   forward_a_e, forward_b_e   : operand mux3 selects (00 regfile, 01 ResultW, 10 ALUResultM)
//   stall_f, stall_d, stall_e  : hold the fetch / decode / execute pipeline register
//   flush_d, flush_e           : bubble the decode / execute pipeline register
// Build option FWD_HAZARD_MULTICYCLE_EN: when defined, multi-cycle ops are sequenced
// by mc_sequencer and hold E; when undefined, multicycle_d is ignored and stall_e is 0.
// All outputs are combinational from the shadow tags, the sequencer and the D inputs.
module forward_hazard_unit
  import pipeline_pkg::*;
#(
  parameter int REG_AW    = 4,
  parameter int MC_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] ra1_d,
  input  logic [REG_AW-1:0] ra2_d,
  input  logic [REG_AW-1:0] wa_d,
  input  logic              reg_write_d,
  input  logic              mem_to_reg_d,
  input  logic              multicycle_d,
  input  logic              branch_taken_e,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              flush_d,
  output logic              flush_e
);

  logic [TAG_AW-1:0] ra1_x, ra2_x, wa_x;
  e_tag_t            e_q;
  mw_tag_t           m_q, w_q;
  logic              lw_hazard;

  assign ra1_x = TAG_AW'(ra1_d);
  assign ra2_x = TAG_AW'(ra2_d);
  assign wa_x  = TAG_AW'(wa_d);

`ifdef FWD_HAZARD_MULTICYCLE_EN
  logic mc_e_q;

  mc_sequencer #(
    .MC_CYCLES(MC_CYCLES)
  ) u_mc_seq (
    .clk    (clk),
    .reset  (reset),
    .mc_e   (mc_e_q),
    .stall_e(stall_e)
  );

  // The multi-cycle flag follows the same hold/bubble/load rule as the other E tags.
  always_ff @(posedge clk) begin
    if (reset) begin
      mc_e_q <= 1'b0;
    end else if (stall_e) begin
      mc_e_q <= mc_e_q;
    end else if (flush_e) begin
      mc_e_q <= 1'b0;
    end else begin
      mc_e_q <= multicycle_d;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = multicycle_d ^ (MC_CYCLES > 1);
  assign stall_e    = 1'b0;
`endif

  assign forward_a_e = fwd_select(e_q.ra1, m_q, w_q);
  assign forward_b_e = fwd_select(e_q.ra2, m_q, w_q);

  // While E is held by a multi-cycle op nothing else may disturb the pipeline, so
  // branch and load-use are only looked at when stall_e is low. A taken branch
  // discards the decode instruction anyway, so it wins over a load-use stall.
  always_comb begin
    lw_hazard = e_q.m2r & e_q.rw & ((e_q.wa == ra1_x) | (e_q.wa == ra2_x));
    stall_f   = stall_e;
    stall_d   = stall_e;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    if (!stall_e) begin
      if (branch_taken_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lw_hazard) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  // Shadow tags: E holds under stall_e, M receives a bubble while E is held so the
  // held op is not seen twice downstream, and W always follows M.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      w_q <= m_q;
      if (stall_e) begin
        m_q <= '0;
      end else begin
        m_q <= '{wa: e_q.wa, rw: e_q.rw};
      end
      if (stall_e) begin
        e_q <= e_q;
      end else if (flush_e) begin
        e_q <= '0;
      end else begin
        e_q <= '{ra1: ra1_x, ra2: ra2_x, wa: wa_x, rw: reg_write_d, m2r: mem_to_reg_d};
      end
    end
  end

endmodule
